// File: rtl/param_datapath_if.sv
// Host-side bundle for param_datapath: run control, code-load port and status outputs.
//   master : host/testbench (drives run and the code port, observes status)
//   slave  : core (observes run and the code port, drives status)
//   run, code_w_en, code_addr_in[ADDR_W], code_in[16]   host -> core
//   debug[DATA_W], pc_out[ADDR_W], flags{N,C,Z}, busy, halted   core -> host
interface param_datapath_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 9
) ();
  logic              run;
  logic              code_w_en;
  logic [ADDR_W-1:0] code_addr_in;
  logic [15:0]       code_in;
  logic [DATA_W-1:0] debug;
  logic [ADDR_W-1:0] pc_out;
  logic [2:0]        flags;
  logic              busy;
  logic              halted;

  modport master (
    output run, code_w_en, code_addr_in, code_in,
    input  debug, pc_out, flags, busy, halted
  );

  modport slave (
    input  run, code_w_en, code_addr_in, code_in,
    output debug, pc_out, flags, busy, halted
  );
endinterface

// File: rtl/param_datapath.sv
// Parametrised 16-bit-instruction core: sequencer FSM, 8 x DATA_W register file, ALU with
// {N,C,Z} flags, 2**ADDR_W x 16 code memory, conditional jumps and HALT.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset (code memory is not reset)
//   bus    : slave side of param_datapath_if (run, code write port, debug/pc_out/flags/busy/halted)
module param_datapath #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 9
) (
  input  logic            clk,
  input  logic            rst_n,
  param_datapath_if.slave bus
);

  localparam int unsigned MEM_DEPTH = 2 ** ADDR_W;
  localparam int unsigned NUM_REGS  = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_EXEC,
    S_HALTED
  } state_t;

  state_t            state_q, state_d;
  logic              busy_q, halted_q;
  logic [15:0]       mem [MEM_DEPTH];
  logic [15:0]       mem_rdata;
  logic [15:0]       ir;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [2:0]        flags_q;
  logic [DATA_W-1:0] debug_q;

  // Instruction fields
  logic [4:0]        op;
  logic [2:0]        rd, ra, rb;
  logic [DATA_W-1:0] opa, opb, imm;
  logic [ADDR_W-1:0] tgt;

  assign op  = ir[15:11];
  assign rd  = ir[10:8];
  assign ra  = ir[5:3];
  assign rb  = ir[2:0];
  assign imm = DATA_W'(ir[7:0]);
  assign tgt = ir[ADDR_W-1:0];
  assign opa = regs[ra];
  assign opb = regs[rb];

  // Opcode classes; CMP (01001) reuses the ALU SUB path since op[2:0] is 001
  logic is_alu, is_movi, is_cmp, is_jump, is_halt;
  assign is_alu  = (op[4:3] == 2'b00);
  assign is_movi = (op == 5'b01000);
  assign is_cmp  = (op == 5'b01001);
  assign is_jump = (op[4:2] == 3'b100);
  assign is_halt = (op == 5'b11111);

  // ALU
  logic [DATA_W-1:0] alu_res;
  logic              alu_c;
  logic [DATA_W:0]   sum;
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    sum     = '0;
    case (op[2:0])
      3'b000: begin
        sum     = {1'b0, opa} + {1'b0, opb};
        alu_res = sum[DATA_W-1:0];
        alu_c   = sum[DATA_W];
      end
      3'b001: begin
        alu_res = opa - opb;
        alu_c   = (opa < opb);
      end
      3'b010: alu_res = opa & opb;
      3'b011: alu_res = opa | opb;
      3'b100: alu_res = opa ^ opb;
      3'b101: alu_res = ~opa;
      3'b110: begin
        alu_res = opa << 1;
        alu_c   = opa[DATA_W-1];
      end
      3'b111: begin
        alu_res = opa >> 1;
        alu_c   = opa[0];
      end
    endcase
  end

  logic [2:0] alu_flags;
  assign alu_flags = {alu_res[DATA_W-1], alu_c, (alu_res == '0)};

  // Jump condition from the flags held before this instruction
  logic jmp_take;
  always_comb begin
    jmp_take = 1'b0;
    if (is_jump) begin
      case (op[1:0])
        2'b00: jmp_take = 1'b1;
        2'b01: jmp_take = flags_q[0];
        2'b10: jmp_take = ~flags_q[0];
        2'b11: jmp_take = flags_q[1];
      endcase
    end
  end

  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  assign wr_en   = is_alu | is_movi;
  assign wr_data = is_movi ? imm : alu_res;

  // Sequencer next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (bus.run) state_d = S_FETCH;
      S_FETCH:  state_d = S_LOAD;
      S_LOAD:   state_d = S_EXEC;
      S_EXEC: begin
        if (is_halt)      state_d = S_HALTED;
        else if (bus.run) state_d = S_FETCH;
        else              state_d = S_IDLE;
      end
      S_HALTED: if (!bus.run) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // State register with registered status decodes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      busy_q   <= (state_d == S_FETCH) || (state_d == S_LOAD) || (state_d == S_EXEC);
      halted_q <= (state_d == S_HALTED);
    end
  end

  // Code memory: host writes only while stopped; read is always at pc
  logic code_wr;
  assign code_wr = bus.code_w_en && ((state_q == S_IDLE) || (state_q == S_HALTED));

  always_ff @(posedge clk) begin
    if (code_wr) mem[bus.code_addr_in] <= bus.code_in;
    mem_rdata <= mem[pc];
  end

  // Datapath: instruction latch, pc, register file, flags, debug
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir      <= '0;
      pc      <= '0;
      flags_q <= '0;
      debug_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      case (state_q)
        S_LOAD: begin
          ir <= mem_rdata;
          pc <= pc + ADDR_W'(1);
        end
        S_EXEC: begin
          if (wr_en) begin
            regs[rd] <= wr_data;
            debug_q  <= wr_data;
          end
          if (is_alu || is_cmp) flags_q <= alu_flags;
          if (jmp_take) pc <= tgt;
        end
        S_HALTED: if (!bus.run) pc <= '0;
        default: ;
      endcase
    end
  end

  assign bus.debug  = debug_q;
  assign bus.pc_out = pc;
  assign bus.flags  = flags_q;
  assign bus.busy   = busy_q;
  assign bus.halted = halted_q;

endmodule

// File: tb/tb_param_datapath.sv
// Scoreboard bench for param_datapath: an instruction-level reference model predicts the
// architectural state after every instruction; a monitor retires instructions by watching
// busy (3 cycles per instruction) and compares pc_out/debug/flags/halted.
module tb_param_datapath;

  localparam int unsigned DW  = 8;
  localparam int unsigned AW  = 9;
  localparam int unsigned DW4 = 6;
  localparam int unsigned AW4 = 4;
  localparam int MASK  = (1 << DW) - 1;
  localparam int MSB   = 1 << (DW - 1);
  localparam int AMASK = (1 << AW) - 1;
  localparam logic [15:0] HALT = 16'hF800;
  localparam logic [15:0] NOP  = 16'h5000;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  param_datapath_if #(.DATA_W(DW),  .ADDR_W(AW))  bus  ();
  param_datapath_if #(.DATA_W(DW4), .ADDR_W(AW4)) bus4 ();

  param_datapath #(.DATA_W(DW),  .ADDR_W(AW))  u_dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
  param_datapath #(.DATA_W(DW4), .ADDR_W(AW4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

  typedef struct {
    int pc;
    int dbg;
    int flg;
    int hlt;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   n_ret = 0;

  // Reference model state
  int m_reg [8];
  int m_flg, m_dbg, m_pc;
  int m_mem [1 << AW];
  logic [15:0] prog[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] e_alu(int f, int rd, int ra, int rb);
    return {2'b00, 3'(f), 3'(rd), 2'b00, 3'(ra), 3'(rb)};
  endfunction
  function automatic logic [15:0] e_movi(int rd, int imm);
    return {5'b01000, 3'(rd), 8'(imm)};
  endfunction
  function automatic logic [15:0] e_jmp(int cond, int tgt);
    return {3'b100, 2'(cond), 11'(tgt)};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_reg[i] = 0;
    m_flg = 0; m_dbg = 0; m_pc = 0;
  endtask

  // Executes from m_pc until HALT, pushing the expected state after each instruction
  task automatic model_run(output int n);
    int w, op, rd, a, b, res, c, s;
    bit halt, wr, fl, tk;
    n = 0;
    halt = 0;
    while (!halt && n < 1000) begin
      w = m_mem[m_pc];
      m_pc = (m_pc + 1) & AMASK;
      op = w >> 11;
      rd = (w >> 8) & 7;
      a = m_reg[(w >> 3) & 7];
      b = m_reg[w & 7];
      wr = 0; fl = 0; res = 0; c = 0; tk = 0;
      if (op < 8 || op == 9) begin
        fl = 1;
        wr = (op < 8);
        case (op & 7)
          0: begin s = a + b; res = s & MASK; c = int'(s > MASK); end
          1: begin res = (a - b) & MASK; c = int'(a < b); end
          2: res = a & b;
          3: res = a | b;
          4: res = a ^ b;
          5: res = MASK - a;
          6: begin s = a * 2; res = s & MASK; c = int'(s > MASK); end
          default: begin res = a / 2; c = a % 2; end
        endcase
      end else if (op == 8) begin
        wr = 1;
        res = (w & 255) & MASK;
      end else if (op >= 16 && op <= 19) begin
        case (op - 16)
          0: tk = 1;
          1: tk = (m_flg & 1) != 0;
          2: tk = (m_flg & 1) == 0;
          default: tk = (m_flg & 2) != 0;
        endcase
        if (tk) m_pc = w & AMASK;
      end else if (op == 31) begin
        halt = 1;
      end
      if (wr) begin
        m_reg[rd] = res;
        m_dbg = res;
      end
      if (fl) m_flg = (res >= MSB ? 4 : 0) + (c != 0 ? 2 : 0) + (res == 0 ? 1 : 0);
      exp_q.push_back('{m_pc, m_dbg, m_flg, int'(halt)});
      n++;
    end
  endtask

  task automatic load_prog();
    foreach (prog[i]) begin
      bus.code_w_en    = 1'b1;
      bus.code_addr_in = AW'(i);
      bus.code_in      = prog[i];
      m_mem[i]         = int'(prog[i]);
      @(posedge clk); #1;
    end
    bus.code_w_en = 1'b0;
  endtask

  // Runs until halted (optionally with random run drops), bounded by a cycle budget
  task automatic wait_halt(input int n, input bit pauses);
    int cyc;
    bit done;
    cyc = 0;
    done = 0;
    bus.run = 1'b1;
    while (!done && cyc < 4000) begin
      @(posedge clk); #1;
      cyc++;
      if (bus.halted) done = 1;
      else if (pauses && bus.busy && (n_ret + 2 < n) && $urandom_range(0, 5) == 0) begin
        bus.run = 1'b0;
        repeat ($urandom_range(1, 6)) begin
          @(posedge clk); #1;
          cyc++;
        end
        bus.run = 1'b1;
      end
    end
    chk("halt_reached", 32'(done), 1);
    @(negedge clk);
  endtask

  // HALTED -> IDLE with pc cleared
  task automatic release_halt();
    bus.run = 1'b0;
    @(posedge clk); #1;
    chk("release_pc", 32'(bus.pc_out), 0);
    chk("release_halted", 32'(bus.halted), 0);
    chk("release_busy", 32'(bus.busy), 0);
    chk("queue_drained", 32'(exp_q.size()), 0);
    exp_q.delete();
    m_pc = 0;
  endtask

  task automatic go(input bit pauses);
    int n;
    n_ret = 0;
    model_run(n);
    wait_halt(n, pauses);
    release_halt();
  endtask

  // Monitor: an instruction retires on the first sample after its three busy cycles
  int ph = 0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      ph = 0;
    end else begin
      if (ph == 3) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL retire_unexpected: pc %0d with no expected entry", bus.pc_out);
        end else begin
          e = exp_q.pop_front();
          chk("ret_pc", 32'(bus.pc_out), e.pc);
          chk("ret_debug", 32'(bus.debug), e.dbg);
          chk("ret_flags", 32'(bus.flags), e.flg);
          chk("ret_halted", 32'(bus.halted), e.hlt);
        end
        n_ret++;
        ph = 0;
      end
      if (bus.busy) ph++;
    end
  end

  initial begin
    int n, len, tgt;
    bus.run = 1'b0; bus.code_w_en = 1'b0; bus.code_addr_in = '0; bus.code_in = '0;
    bus4.run = 1'b0; bus4.code_w_en = 1'b0; bus4.code_addr_in = '0; bus4.code_in = '0;
    rst_n = 1'b0;
    model_reset();
    #2;
    chk("rst_debug", 32'(bus.debug), 0);
    chk("rst_pc", 32'(bus.pc_out), 0);
    chk("rst_flags", 32'(bus.flags), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_halted", 32'(bus.halted), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Small core: NOPs everywhere
    for (int i = 0; i < 16; i++) begin
      bus4.code_w_en = 1'b1; bus4.code_addr_in = AW4'(i); bus4.code_in = NOP;
      @(posedge clk); #1;
    end
    bus4.code_w_en = 1'b0;

    // Basic program: 5 + 3
    prog = '{e_movi(1, 5), e_movi(2, 3), e_alu(0, 3, 1, 2), HALT};
    load_prog();
    n_ret = 0;
    model_run(n);
    wait_halt(n, 0);
    chk("t1_debug", 32'(bus.debug), 8);
    chk("t1_flags", 32'(bus.flags), 0);
    chk("t1_pc", 32'(bus.pc_out), 4);
    release_halt();

    // SUB borrow and ADD wrap to zero
    prog = '{e_movi(1, 3), e_movi(2, 5), e_alu(1, 3, 1, 2), e_movi(4, 255), e_movi(5, 1),
             e_alu(0, 6, 4, 5), HALT};
    load_prog();
    go(0);

    // Count-down loop with JNZ, with run drops
    prog = '{e_movi(1, 3), e_movi(2, 1), e_alu(1, 1, 1, 2), e_jmp(2, 2), HALT};
    load_prog();
    go(1);
    chk("t3_flags_z", 32'(bus.flags & 3'b001), 1);

    // Reset during EXEC of the ADD
    prog = '{e_movi(1, 5), e_movi(2, 3), e_alu(0, 3, 1, 2), HALT};
    load_prog();
    n_ret = 0;
    model_run(n);
    void'(exp_q.pop_back());
    void'(exp_q.pop_back());
    bus.run = 1'b1;
    repeat (9) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_debug", 32'(bus.debug), 0);
    chk("mid_rst_pc", 32'(bus.pc_out), 0);
    chk("mid_rst_flags", 32'(bus.flags), 0);
    chk("mid_rst_busy", 32'(bus.busy), 0);
    chk("mid_rst_retired", 32'(n_ret), 2);
    chk("mid_rst_queue", 32'(exp_q.size()), 0);
    exp_q.delete();
    bus.run = 1'b0;
    model_reset();
    @(posedge clk); #1 rst_n = 1'b1;

    // Code writes while busy must be ignored
    n_ret = 0;
    model_run(n);
    bus.run = 1'b1;
    @(posedge clk); #1;
    bus.code_w_en = 1'b1; bus.code_addr_in = AW'(2); bus.code_in = e_movi(3, 8'h77);
    repeat (4) @(posedge clk);
    #1 bus.code_w_en = 1'b0;
    wait_halt(n, 0);
    chk("busy_write_debug", 32'(bus.debug), 8);
    release_halt();

    // Random forward-branching programs with random run drops
    for (int t = 0; t < 20; t++) begin
      len = $urandom_range(4, 24);
      prog.delete();
      for (int i = 0; i < len - 1; i++) begin
        case ($urandom_range(0, 7))
          0, 1, 2, 3: prog.push_back({2'b00, 14'($urandom)});
          4:          prog.push_back({5'b01000, 11'($urandom)});
          5:          prog.push_back({5'b01001, 11'($urandom)});
          6:          prog.push_back($urandom_range(0, 1) ? {5'(10 + $urandom_range(0, 5)), 11'($urandom)}
                                                          : {5'(20 + $urandom_range(0, 10)), 11'($urandom)});
          default: begin
            tgt = $urandom_range(i + 1, len - 1);
            prog.push_back({3'b100, 2'($urandom), 2'($urandom), 9'(tgt)});
          end
        endcase
      end
      prog.push_back(HALT);
      load_prog();
      go(1);
    end

    // Small core: pc wraps 15 -> 0 and keeps cycling
    bus4.run = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("wrap_pc_first", 32'(bus4.pc_out), 1);
    for (int k = 1; k < 40; k++) begin
      repeat (3) @(posedge clk);
      #1 chk("wrap_pc", 32'(bus4.pc_out), (k + 1) % 16);
    end
    bus4.run = 1'b0;
    repeat (4) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
